// File: rtl/node_pkg.sv
// Shared types for the valid/ready node endpoints.
package node_pkg;

  // Source endpoint FSM states; later endpoints reuse this encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } src_state_t;

endpackage : node_pkg

// File: rtl/node_down_counter.sv
// Loadable down-counter. Load takes priority over decrement.
// A decrement at zero is ignored, so the counter never wraps.
module node_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_count;

  // Count register: reset to zero, load, or decrement while non-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= ZERO_W;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != ZERO_W)) begin
      r_count <= r_count - ONE_W;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == ZERO_W);

endmodule : node_down_counter

// File: rtl/node_stream_source.sv
// Transmitting endpoint of the valid/ready node chain. On start it emits
// cfg_len words (base + i*stride) with optional idle gaps between beats.
module node_stream_source
  import node_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16,
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [WIDTH-1:0] cfg_base,
  input  logic [WIDTH-1:0] cfg_stride,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             ready_down_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_down_out,
  output logic             last_down_out,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] beat_count
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_TWO  = {{(LEN_W-2){1'b0}}, 2'b10};
  localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DAT_ZERO = {WIDTH{1'b0}};

  src_state_t       r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_last;
  logic             r_busy;
  logic             r_done;
  logic [LEN_W-1:0] r_beat_count;
  logic [WIDTH-1:0] r_stride;
  logic [GAP_W-1:0] r_gap;

  src_state_t       w_state_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_valid_nxt;
  logic             w_last_nxt;
  logic             w_done_nxt;
  logic [LEN_W-1:0] w_beat_count_nxt;
  logic [WIDTH-1:0] w_stride_nxt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic             w_rem_load;
  logic             w_rem_dec;
  logic             w_gap_load;
  logic             w_gap_dec;
  logic [LEN_W-1:0] w_rem;
  logic             w_rem_zero;
  logic [GAP_W-1:0] w_gap_cnt;
  logic             w_gap_zero;
  logic             w_fire;

  assign w_fire = r_valid & ready_down_in;

  // Beats still to be fired in the current burst, including the one on the bus.
  node_down_counter #(.W(LEN_W)) u_rem_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_rem_load),
    .i_load_val (cfg_len),
    .i_dec      (w_rem_dec),
    .o_count    (w_rem),
    .o_zero     (w_rem_zero)
  );

  // Idle cycles left before the next beat is presented.
  node_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_gap_load),
    .i_load_val (r_gap),
    .i_dec      (w_gap_dec),
    .o_count    (w_gap_cnt),
    .o_zero     (w_gap_zero)
  );

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    w_state_nxt      = r_state;
    w_data_nxt       = r_data;
    w_valid_nxt      = r_valid;
    w_last_nxt       = r_last;
    w_done_nxt       = 1'b0;
    w_beat_count_nxt = r_beat_count;
    w_stride_nxt     = r_stride;
    w_gap_nxt        = r_gap;
    w_rem_load       = 1'b0;
    w_rem_dec        = 1'b0;
    w_gap_load       = 1'b0;
    w_gap_dec        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_beat_count_nxt = LEN_ZERO;
          w_stride_nxt     = cfg_stride;
          w_gap_nxt        = cfg_gap;
          w_rem_load       = 1'b1;
          if (cfg_len != LEN_ZERO) begin
            w_state_nxt = SEND;
            w_valid_nxt = 1'b1;
            w_data_nxt  = cfg_base;
            w_last_nxt  = (cfg_len == LEN_ONE);
          end else begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
        end
      end
      SEND: begin
        if (w_fire) begin
          w_beat_count_nxt = r_beat_count + LEN_ONE;
          w_rem_dec        = 1'b1;
          if (w_rem == LEN_ONE) begin
            w_state_nxt = DONE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_data_nxt = r_data + r_stride;
            if (r_gap == GAP_ZERO) begin
              w_last_nxt = (w_rem == LEN_TWO);
            end else begin
              w_state_nxt = GAP;
              w_valid_nxt = 1'b0;
              w_last_nxt  = 1'b0;
              w_gap_load  = 1'b1;
            end
          end
        end else begin
          w_valid_nxt = 1'b1;
        end
      end
      GAP: begin
        // Remaining count was already decremented by the fire that entered GAP.
        if (w_gap_zero || (w_gap_cnt == GAP_ONE)) begin
          w_state_nxt = SEND;
          w_valid_nxt = 1'b1;
          w_last_nxt  = (w_rem == LEN_ONE);
        end else begin
          w_gap_dec = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides any in-flight burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_data       <= DAT_ZERO;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_beat_count <= LEN_ZERO;
      r_stride     <= DAT_ZERO;
      r_gap        <= GAP_ZERO;
    end else begin
      r_state      <= w_state_nxt;
      r_data       <= w_data_nxt;
      r_valid      <= w_valid_nxt;
      r_last       <= w_last_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_done       <= w_done_nxt;
      r_beat_count <= w_beat_count_nxt;
      r_stride     <= w_stride_nxt;
      r_gap        <= w_gap_nxt;
    end
  end

  assign data_out       = r_data;
  assign valid_down_out = r_valid;
  assign last_down_out  = r_last;
  assign busy           = r_busy;
  assign done           = r_done;
  assign beat_count     = r_beat_count;

endmodule : node_stream_source
